timer_apb_regs: RTL and testbench

- APB slave register front-end of the 8-bit timer; directly downstream of the APB master bus driver, upstream of the counter core.
- Decodes APB transfers into TDR/TCR/TSR, returns TCNT on read, holds OVF/UDF sticky flags with write-1-to-clear.
- Tracks APB phases with an explicit FSM and drives PREADY/PSLVERR/PRDATA.

---
 rtl/timer_apb_regs.sv | 205 ++++++++++++++++++++
 tb/tb_timer_apb_regs.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_apb_regs.sv
// APB slave register front-end of the 8-bit timer: TDR/TCR/TSR/TCNT decode and sticky W1C flags.
// Define TIMER_APB_WAIT_STATE_EN to insert one PREADY=0 wait cycle into every transfer.
module timer_apb_regs #(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] TDR_ADDR   = 8'h00,
   parameter logic [ADDR_WIDTH-1:0] TCR_ADDR   = 8'h01,
   parameter logic [ADDR_WIDTH-1:0] TSR_ADDR   = 8'h02,
   parameter logic [ADDR_WIDTH-1:0] TCNT_ADDR  = 8'h03
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR,
   input  logic [DATA_WIDTH-1:0] tcnt_i,
   input  logic                  ovf_set_i,
   input  logic                  udf_set_i,
   output logic [DATA_WIDTH-1:0] tdr_o,
   output logic                  tcr_load_o,
   output logic                  tcr_updown_o,
   output logic                  tcr_en_o,
   output logic [1:0]            tcr_cks_o
);

   // state_q names the bus phase completed at the most recent edge
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_WAIT   = 2'd3
   } state_t;

   state_t                 state_q;
   logic [DATA_WIDTH-1:0]  prdata_q;
   logic                   pslverr_q;

   logic [DATA_WIDTH-1:0]  tdr_q, tdr_d;
   logic                   tcr_load_q, tcr_load_d;
   logic                   tcr_updown_q, tcr_updown_d;
   logic                   tcr_en_q, tcr_en_d;
   logic [1:0]             tcr_cks_q, tcr_cks_d;
   logic                   ovf_q, ovf_d;
   logic                   udf_q, udf_d;

   logic                   setup_s;
   logic                   access_s;
   logic                   start_s;
   logic                   capture_s;
   logic                   commit_s;
   logic                   wr_commit_s;
   logic                   tsr_w1c_s;
   logic                   mapped_s;
   logic [DATA_WIDTH-1:0]  rd_mux_s;
   logic [DATA_WIDTH-1:0]  tcr_rd_s;
   logic [DATA_WIDTH-1:0]  tsr_rd_s;

   assign setup_s  = PSEL & ~PENABLE;
   assign access_s = PSEL & PENABLE;
   // a setup phase is only legal while idle or right after a completed access
   assign start_s  = setup_s & ((state_q == S_IDLE) | (state_q == S_ACCESS));

`ifdef TIMER_APB_WAIT_STATE_EN
   logic pready_q;

   assign capture_s = (state_q == S_SETUP) & access_s;
   assign commit_s  = (state_q == S_WAIT) & access_s;
   assign PREADY    = pready_q;
`else
   assign capture_s = start_s;
   assign commit_s  = (state_q == S_SETUP) & access_s;
   assign PREADY    = 1'b1;
`endif

   assign wr_commit_s = commit_s & PWRITE & mapped_s;
   assign tsr_w1c_s   = wr_commit_s & (PADDR == TSR_ADDR);

   // Readback images of the control and status registers
   always_comb begin
      tcr_rd_s      = {DATA_WIDTH{1'b0}};
      tcr_rd_s[7]   = tcr_load_q;
      tcr_rd_s[5]   = tcr_updown_q;
      tcr_rd_s[4]   = tcr_en_q;
      tcr_rd_s[1:0] = tcr_cks_q;
      tsr_rd_s      = {DATA_WIDTH{1'b0}};
      tsr_rd_s[0]   = ovf_q;
      tsr_rd_s[1]   = udf_q;
   end

   // Address decode and read-data selection
   always_comb begin
      mapped_s = 1'b0;
      rd_mux_s = {DATA_WIDTH{1'b0}};
      case (PADDR)
         TDR_ADDR: begin
            mapped_s = 1'b1;
            rd_mux_s = tdr_q;
         end
         TCR_ADDR: begin
            mapped_s = 1'b1;
            rd_mux_s = tcr_rd_s;
         end
         TSR_ADDR: begin
            mapped_s = 1'b1;
            rd_mux_s = tsr_rd_s;
         end
         TCNT_ADDR: begin
            mapped_s = 1'b1;
            rd_mux_s = tcnt_i;
         end
         default: begin
            mapped_s = 1'b0;
            rd_mux_s = {DATA_WIDTH{1'b0}};
         end
      endcase
   end

   // Register next-state: write commits and sticky flags (a set pulse beats a same-cycle W1C)
   always_comb begin
      tdr_d        = tdr_q;
      tcr_load_d   = tcr_load_q;
      tcr_updown_d = tcr_updown_q;
      tcr_en_d     = tcr_en_q;
      tcr_cks_d    = tcr_cks_q;
      if (wr_commit_s && (PADDR == TDR_ADDR)) begin
         tdr_d = PWDATA;
      end else if (wr_commit_s && (PADDR == TCR_ADDR)) begin
         tcr_load_d   = PWDATA[7];
         tcr_updown_d = PWDATA[5];
         tcr_en_d     = PWDATA[4];
         tcr_cks_d    = PWDATA[1:0];
      end else begin
         tdr_d = tdr_q;
      end
      ovf_d = ovf_set_i | (ovf_q & ~(tsr_w1c_s & PWDATA[0]));
      udf_d = udf_set_i | (udf_q & ~(tsr_w1c_s & PWDATA[1]));
   end

   // Register file storage
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         tdr_q        <= {DATA_WIDTH{1'b0}};
         tcr_load_q   <= 1'b0;
         tcr_updown_q <= 1'b0;
         tcr_en_q     <= 1'b0;
         tcr_cks_q    <= 2'b00;
         ovf_q        <= 1'b0;
         udf_q        <= 1'b0;
      end else begin
         tdr_q        <= tdr_d;
         tcr_load_q   <= tcr_load_d;
         tcr_updown_q <= tcr_updown_d;
         tcr_en_q     <= tcr_en_d;
         tcr_cks_q    <= tcr_cks_d;
         ovf_q        <= ovf_d;
         udf_q        <= udf_d;
      end
   end

   // APB phase FSM with registered PRDATA/PSLVERR/PREADY
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q   <= S_IDLE;
         prdata_q  <= {DATA_WIDTH{1'b0}};
         pslverr_q <= 1'b0;
`ifdef TIMER_APB_WAIT_STATE_EN
         pready_q  <= 1'b1;
`endif
      end else begin
         case (state_q)
            S_IDLE, S_ACCESS: state_q <= setup_s ? S_SETUP : S_IDLE;
`ifdef TIMER_APB_WAIT_STATE_EN
            S_SETUP:          state_q <= access_s ? S_WAIT : S_IDLE;
`else
            S_SETUP:          state_q <= access_s ? S_ACCESS : S_IDLE;
`endif
            S_WAIT:           state_q <= access_s ? S_ACCESS : S_IDLE;
            default:          state_q <= S_IDLE;
         endcase
         if (capture_s && !PWRITE) begin
            prdata_q <= rd_mux_s;
         end else begin
            prdata_q <= prdata_q;
         end
         pslverr_q <= capture_s & ~mapped_s;
`ifdef TIMER_APB_WAIT_STATE_EN
         pready_q  <= ~start_s;
`endif
      end
   end

   assign PRDATA       = prdata_q;
   assign PSLVERR      = pslverr_q;
   assign tdr_o        = tdr_q;
   assign tcr_load_o   = tcr_load_q;
   assign tcr_updown_o = tcr_updown_q;
   assign tcr_en_o     = tcr_en_q;
   assign tcr_cks_o    = tcr_cks_q;

endmodule

// File: tb/tb_timer_apb_regs.sv
// Directed, table-driven bench for timer_apb_regs plus hand-written multi-cycle sequences.
module tb_timer_apb_regs;

   logic       PCLK = 1'b0;
   logic       PRESETn;
   logic       PSEL;
   logic       PENABLE;
   logic       PWRITE;
   logic [7:0] PADDR;
   logic [7:0] PWDATA;
   logic [7:0] PRDATA;
   logic       PREADY;
   logic       PSLVERR;
   logic [7:0] tcnt_i;
   logic       ovf_set_i;
   logic       udf_set_i;
   logic [7:0] tdr_o;
   logic       tcr_load_o;
   logic       tcr_updown_o;
   logic       tcr_en_o;
   logic [1:0] tcr_cks_o;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] rd_data;
   logic       rd_err;
   int         n_waits;
   int         low_cycles;

`ifdef TIMER_APB_WAIT_STATE_EN
   localparam int EXP_WAITS = 1;
`else
   localparam int EXP_WAITS = 0;
`endif

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rd;
      logic       exp_err;
      logic [7:0] exp_tdr;
      logic [4:0] exp_tcr;   // {load, updown, en, cks}
   } vec_t;

   vec_t tbl[16];

   always #5 PCLK = ~PCLK;

   timer_apb_regs dut (
      .PCLK         (PCLK),
      .PRESETn      (PRESETn),
      .PSEL         (PSEL),
      .PENABLE      (PENABLE),
      .PWRITE       (PWRITE),
      .PADDR        (PADDR),
      .PWDATA       (PWDATA),
      .PRDATA       (PRDATA),
      .PREADY       (PREADY),
      .PSLVERR      (PSLVERR),
      .tcnt_i       (tcnt_i),
      .ovf_set_i    (ovf_set_i),
      .udf_set_i    (udf_set_i),
      .tdr_o        (tdr_o),
      .tcr_load_o   (tcr_load_o),
      .tcr_updown_o (tcr_updown_o),
      .tcr_en_o     (tcr_en_o),
      .tcr_cks_o    (tcr_cks_o)
   );

   function automatic logic [7:0] tcr_bits();
      return {3'b000, tcr_load_o, tcr_updown_o, tcr_en_o, tcr_cks_o};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 8'h%02h, expected 8'h%02h", name, act, exp);
      end
   endtask

   // One APB transfer, entered and left at posedge+1; b2b leaves the bus selected for a following setup.
   task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                           input logic pulse_udf, input logic late_en, input logic [7:0] late_tcnt,
                           input logic b2b,
                           output logic [7:0] rdata, output logic err, output int waits);
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = wr;
      PADDR   = addr;
      PWDATA  = wdata;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      waits   = 0;
      while (!PREADY && waits < 8) begin
         @(posedge PCLK); #1;
         waits++;
      end
      if (!PREADY) begin
         n_vec++;
         n_err++;
         $display("FAIL pready_timeout: PREADY got 0, expected 1 within 8 cycles");
      end
      if (late_en) tcnt_i = late_tcnt;
      if (pulse_udf) udf_set_i = 1'b1;
      #1;
      rdata = PRDATA;
      err   = PSLVERR;
      @(posedge PCLK); #1;
      udf_set_i = 1'b0;
      if (!b2b) begin
         PSEL    = 1'b0;
         PENABLE = 1'b0;
         @(posedge PCLK); #1;
      end
   endtask

   task automatic rd(input logic [7:0] addr);
      apb_xfer(1'b0, addr, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, rd_data, rd_err, n_waits);
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      apb_xfer(1'b1, addr, data, 1'b0, 1'b0, 8'h00, 1'b0, rd_data, rd_err, n_waits);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation got no finish, expected finish before 200us");
      $fatal(1);
   end

   initial begin
      //            wr    addr   wdata  exp_rd exp_err exp_tdr exp_tcr
      tbl[0]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 5'b00000};
      tbl[1]  = '{1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 8'h00, 5'b00000};
      tbl[2]  = '{1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 8'h00, 5'b00000};
      tbl[3]  = '{1'b0, 8'h03, 8'h00, 8'h00, 1'b0, 8'h00, 5'b00000};
      tbl[4]  = '{1'b1, 8'h00, 8'hA5, 8'h00, 1'b0, 8'hA5, 5'b00000};
      tbl[5]  = '{1'b1, 8'h01, 8'hFF, 8'h00, 1'b0, 8'hA5, 5'b11111};
      tbl[6]  = '{1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 8'hA5, 5'b11111};
      tbl[7]  = '{1'b0, 8'h01, 8'h00, 8'hB3, 1'b0, 8'hA5, 5'b11111};
      tbl[8]  = '{1'b1, 8'h03, 8'h11, 8'h00, 1'b0, 8'hA5, 5'b11111};
      tbl[9]  = '{1'b1, 8'h10, 8'h55, 8'h00, 1'b1, 8'hA5, 5'b11111};
      tbl[10] = '{1'b0, 8'h10, 8'h00, 8'h00, 1'b1, 8'hA5, 5'b11111};
      tbl[11] = '{1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 8'hA5, 5'b11111};
      tbl[12] = '{1'b1, 8'h01, 8'h24, 8'h00, 1'b0, 8'hA5, 5'b01000};
      tbl[13] = '{1'b0, 8'h01, 8'h00, 8'h20, 1'b0, 8'hA5, 5'b01000};
      tbl[14] = '{1'b1, 8'h01, 8'h93, 8'h00, 1'b0, 8'hA5, 5'b10111};
      tbl[15] = '{1'b0, 8'h01, 8'h00, 8'h93, 1'b0, 8'hA5, 5'b10111};

      PRESETn   = 1'b0;
      PSEL      = 1'b0;
      PENABLE   = 1'b0;
      PWRITE    = 1'b0;
      PADDR     = 8'h00;
      PWDATA    = 8'h00;
      tcnt_i    = 8'h00;
      ovf_set_i = 1'b1;
      udf_set_i = 1'b1;
      repeat (3) @(posedge PCLK);
      #1;
      PRESETn   = 1'b1;
      ovf_set_i = 1'b0;
      udf_set_i = 1'b0;
      check("reset_prdata", PRDATA, 8'h00);
      check("reset_pslverr", {7'd0, PSLVERR}, 8'h00);
      check("reset_pready", {7'd0, PREADY}, 8'h01);
      check("reset_tdr", tdr_o, 8'h00);
      check("reset_tcr", tcr_bits(), 8'h00);

      for (int i = 0; i < 16; i++) begin
         apb_xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0, 1'b0, 8'h00, 1'b0,
                  rd_data, rd_err, n_waits);
         if (!tbl[i].wr) check($sformatf("v%0d_prdata", i), rd_data, tbl[i].exp_rd);
         check($sformatf("v%0d_pslverr", i), {7'd0, rd_err}, {7'd0, tbl[i].exp_err});
         check($sformatf("v%0d_tdr", i), tdr_o, tbl[i].exp_tdr);
         check($sformatf("v%0d_tcr", i), tcr_bits(), {3'b000, tbl[i].exp_tcr});
         check($sformatf("v%0d_waits", i), n_waits[7:0], EXP_WAITS[7:0]);
      end
      check("post_err_pslverr_low", {7'd0, PSLVERR}, 8'h00);

      // sticky flags and W1C
      ovf_set_i = 1'b1;
      @(posedge PCLK); #1;
      ovf_set_i = 1'b0;
      rd(8'h02);
      check("tsr_ovf_set", rd_data, 8'h01);
      wr(8'h02, 8'hFF);
      rd(8'h02);
      check("tsr_w1c_all", rd_data, 8'h00);
      ovf_set_i = 1'b1;
      udf_set_i = 1'b1;
      @(posedge PCLK); #1;
      ovf_set_i = 1'b0;
      udf_set_i = 1'b0;
      rd(8'h02);
      check("tsr_both_set", rd_data, 8'h03);
      wr(8'h02, 8'h01);
      rd(8'h02);
      check("tsr_w1c_ovf_only", rd_data, 8'h02);
      apb_xfer(1'b1, 8'h02, 8'h02, 1'b1, 1'b0, 8'h00, 1'b0, rd_data, rd_err, n_waits);
      rd(8'h02);
      check("tsr_set_wins", rd_data, 8'h02);
      wr(8'h02, 8'h02);
      rd(8'h02);
      check("tsr_w1c_udf", rd_data, 8'h00);

      // TCNT sampled at capture, later changes ignored; TCNT writes ignored
      tcnt_i = 8'h7E;
      apb_xfer(1'b0, 8'h03, 8'h00, 1'b0, 1'b1, 8'h7F, 1'b0, rd_data, rd_err, n_waits);
      check("tcnt_capture", rd_data, 8'h7E);
      check("tcnt_held_after", PRDATA, 8'h7E);
      wr(8'h03, 8'h11);
      check("tcnt_wr_pslverr", {7'd0, rd_err}, 8'h00);
      check("tcnt_wr_tdr", tdr_o, 8'hA5);
      check("tcnt_wr_tcr", tcr_bits(), 8'h17);
      check("wr_keeps_prdata", PRDATA, 8'h7E);

      // PSEL&PENABLE while idle and a setup without enable: no side effects
      PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 8'h77;
      repeat (2) begin @(posedge PCLK); #1; end
      PENABLE = 1'b0;
      @(posedge PCLK); #1;
      PSEL = 1'b0;
      repeat (2) begin @(posedge PCLK); #1; end
      check("no_access_tdr", tdr_o, 8'hA5);

      // back-to-back write then read
      apb_xfer(1'b1, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b1, rd_data, rd_err, n_waits);
      rd(8'h00);
      check("b2b_read", rd_data, 8'h5A);
      check("b2b_tdr", tdr_o, 8'h5A);

      // reset in the middle of a TDR write, flag pulse during reset
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 8'h3C;
      @(posedge PCLK); #1;
      PENABLE   = 1'b1;
      PRESETn   = 1'b0;
      ovf_set_i = 1'b1;
      @(posedge PCLK); #1;
      PRESETn   = 1'b1;
      ovf_set_i = 1'b0;
      PSEL      = 1'b0;
      PENABLE   = 1'b0;
      check("midrst_tdr", tdr_o, 8'h00);
      check("midrst_tcr", tcr_bits(), 8'h00);
      check("midrst_prdata", PRDATA, 8'h00);
      rd(8'h02);
      check("midrst_tsr", rd_data, 8'h00);
      check("midrst_waits", n_waits[7:0], EXP_WAITS[7:0]);

`ifdef TIMER_APB_WAIT_STATE_EN
      // one wait cycle; TDR visible three cycles after setup
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 8'h3C;
      @(posedge PCLK); #1;
      PENABLE    = 1'b1;
      low_cycles = PREADY ? 0 : 1;
      @(posedge PCLK); #1;
      if (!PREADY) low_cycles++;
      check("ws_tdr_early", tdr_o, 8'h00);
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      check("ws_tdr_update", tdr_o, 8'h3C);
      check("ws_low_cycles", low_cycles[7:0], 8'h01);
      @(posedge PCLK); #1;
      // reset while a TCR write is waiting
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h01; PWDATA = 8'hFF;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      PRESETn = 1'b0;
      @(posedge PCLK); #1;
      PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
      check("ws_rst_tcr", tcr_bits(), 8'h00);
      rd(8'h01);
      check("ws_rst_tcr_read", rd_data, 8'h00);
      check("ws_rst_waits", n_waits[7:0], 8'h01);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
